// File: rtl/dsp_cic_dec_pkg.sv
// Shared CIC decimator derivations: accumulator width, output shift,
// rounding constant and output saturation bounds.
package dsp_cic_dec_pkg;

   // Supported parameter ranges for the decimator.
   localparam int CIC_N_MIN     = 1;
   localparam int CIC_N_MAX     = 5;
   localparam int CIC_LOG2R_MIN = 1;
   localparam int CIC_LOG2R_MAX = 5;

   // Accumulator width: input width grown by the worst-case gain R^N.
   function automatic int cic_w_acc(input int w_din, input int n, input int log2r);
      return w_din + n * log2r;
   endfunction

   // Right shift that removes the R^N gain exactly.
   function automatic int cic_shift(input int n, input int log2r);
      return n * log2r;
   endfunction

   // Half an output LSB, added before the shift for round-half-up.
   function automatic longint cic_round(input int n, input int log2r);
      return longint'(1) <<< (n * log2r - 1);
   endfunction

   // Largest value representable in a signed w-bit output.
   function automatic longint cic_sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   // Smallest value representable in a signed w-bit output.
   function automatic longint cic_sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/dsp_cic_dec_comb_stage.sv
// One CIC comb stage: y = x - x_prev, evaluated only when a valid token
// passes, so the previous-sample register tracks decimated samples only.
module dsp_cic_comb_stage
   import dsp_cic_dec_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] x,
   input  logic                x_val,
   output logic signed [W-1:0] y,
   output logic                y_val
);

   logic signed [W-1:0] prev;

   // Difference against the previous decimated input; valid advances every clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= '0;
         y_val <= 1'b0;
         prev  <= '0;
      end else begin
         y_val <= x_val;
         if (x_val) begin
            y    <= x - prev;
            prev <= x;
         end
      end
   end

endmodule

// File: rtl/dsp_cic_dec.sv
// CIC decimator: N zero-delay integrators at the input rate, decimation
// by R = 2^LOG2R, N pipelined combs, then round, shift out R^N and saturate.
module dsp_cic_dec
   import dsp_cic_dec_pkg::*;
#(
   parameter int N      = 3,
   parameter int LOG2R  = 2,
   parameter int W_DIN  = 16,
   parameter int W_DOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [W_DIN-1:0]  din,
   input  logic                     din_val,
   output logic signed [W_DOUT-1:0] dout,
   output logic                     dout_val
);

   localparam int W_ACC = cic_w_acc(W_DIN, N, LOG2R);
   localparam int SHIFT = cic_shift(N, LOG2R);
   // Output-stage width: room for the rounding carry and the saturation bounds.
   localparam int W_EXT = (W_ACC + 1 > W_DOUT + 1) ? W_ACC + 1 : W_DOUT + 1;

   localparam logic signed [W_EXT-1:0] ROUND  = W_EXT'(cic_round(N, LOG2R));
   localparam logic signed [W_EXT-1:0] SAT_HI = W_EXT'(cic_sat_max(W_DOUT));
   localparam logic signed [W_EXT-1:0] SAT_LO = W_EXT'(cic_sat_min(W_DOUT));

   logic signed [W_ACC-1:0]  din_ext;
   logic [LOG2R-1:0]         phase;
   logic                     dec_strobe;
   logic signed [W_ACC-1:0]  cin;
   logic                     cin_val;
   logic signed [W_ACC-1:0]  comb_y;
   logic                     comb_val;
   logic signed [W_EXT-1:0]  comb_ext;
   logic signed [W_EXT-1:0]  rounded;
   logic signed [W_EXT-1:0]  scaled;
   logic signed [W_DOUT-1:0] dout_next;

   assign din_ext = {{(W_ACC - W_DIN){din[W_DIN-1]}}, din};

   // Integrator chain: each stage adds the freshly updated value of the stage
   // before it, so the whole cascade settles in one clock.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_int
         logic signed [W_ACC-1:0] acc;
         logic signed [W_ACC-1:0] sum;

         if (gi == 0) begin : g_first
            assign sum = acc + din_ext;
         end else begin : g_rest
            assign sum = acc + g_int[gi-1].sum;
         end

         // Accumulate only on input strobes; wrap-around is intentional.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc <= '0;
            end else if (din_val) begin
               acc <= sum;
            end
         end
      end
   endgenerate

   // The R-th strobe of each group is the one that is decimated.
   assign dec_strobe = din_val && (&phase);

   // Phase counter: counts input strobes modulo R, holds between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
      end else if (din_val) begin
         phase <= phase + LOG2R'(1);
      end
   end

   // Capture the updated last-integrator value on the decimation edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cin     <= '0;
         cin_val <= 1'b0;
      end else begin
         cin_val <= dec_strobe;
         if (dec_strobe) begin
            cin <= g_int[N-1].sum;
         end
      end
   end

   // Comb cascade, one register stage per comb.
   generate
      for (gi = 0; gi < N; gi++) begin : g_comb
         logic signed [W_ACC-1:0] x;
         logic                    x_val;
         logic signed [W_ACC-1:0] y;
         logic                    y_val;

         if (gi == 0) begin : g_first
            assign x     = cin;
            assign x_val = cin_val;
         end else begin : g_rest
            assign x     = g_comb[gi-1].y;
            assign x_val = g_comb[gi-1].y_val;
         end

         dsp_cic_comb_stage #(
            .W (W_ACC)
         ) u_comb (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (x),
            .x_val (x_val),
            .y     (y),
            .y_val (y_val)
         );
      end
   endgenerate

   assign comb_y   = g_comb[N-1].y;
   assign comb_val = g_comb[N-1].y_val;

   assign comb_ext = {{(W_EXT - W_ACC){comb_y[W_ACC-1]}}, comb_y};
   assign rounded  = comb_ext + ROUND;
   assign scaled   = rounded >>> SHIFT;

   // Clamp the scaled result into the signed output range.
   always_comb begin
      dout_next = scaled[W_DOUT-1:0];
      if (scaled > SAT_HI) begin
         dout_next = {1'b0, {(W_DOUT - 1){1'b1}}};
      end else if (scaled < SAT_LO) begin
         dout_next = {1'b1, {(W_DOUT - 1){1'b0}}};
      end
   end

   // Output register: new sample and one-cycle strobe, value held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         dout_val <= 1'b0;
      end else begin
         dout_val <= comb_val;
         if (comb_val) begin
            dout <= dout_next;
         end
      end
   end

endmodule

// File: tb/tb_dsp_cic_dec.sv
// Self-checking bench for dsp_cic_dec (N=3, R=4, 16-bit in/out).
// Reference: direct convolution with the CIC impulse response, decimated.
module tb_dsp_cic_dec;

   localparam int N      = 3;
   localparam int LOG2R  = 2;
   localparam int R      = 1 << LOG2R;
   localparam int W_DIN  = 16;
   localparam int W_DOUT = 16;
   localparam int S      = N * LOG2R;
   localparam int L      = N * (R - 1) + 1;
   localparam int LAT    = N + 1;

   logic                     clk;
   logic                     rst_n;
   logic signed [W_DIN-1:0]  din;
   logic                     din_val;
   logic signed [W_DOUT-1:0] dout;
   logic                     dout_val;

   dsp_cic_dec #(
      .N      (N),
      .LOG2R  (LOG2R),
      .W_DIN  (W_DIN),
      .W_DOUT (W_DOUT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_val  (din_val),
      .dout     (dout),
      .dout_val (dout_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int  due;
      int  val;
      real fval;
   } exp_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     edge_cnt = 0;
   longint h [L];
   int     hist [$];
   int     phase_m  = 0;
   exp_t   expq [$];
   int     last_dout = 0;
   int     obs_val [$];
   int     obs_cyc [$];

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         if (n_fail <= 60)
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // CIC impulse response = N-fold convolution of a length-R boxcar.
   initial begin
      longint tmp [L];
      for (int i = 0; i < L; i++) h[i] = (i == 0) ? 1 : 0;
      for (int s = 0; s < N; s++) begin
         for (int i = 0; i < L; i++) begin
            tmp[i] = 0;
            for (int j = 0; j < R; j++)
               if (i - j >= 0) tmp[i] += h[i - j];
         end
         for (int i = 0; i < L; i++) h[i] = tmp[i];
      end
   end

   // Reference model: filter the input history, keep every R-th result.
   always @(posedge clk) begin
      longint acc;
      longint v;
      edge_cnt++;
      if (!rst_n) begin
         hist.delete();
         expq.delete();
         phase_m   = 0;
         last_dout = 0;
      end else if (din_val) begin
         hist.push_back(int'(din));
         if (hist.size() > L) void'(hist.pop_front());
         phase_m++;
         if (phase_m == R) begin
            phase_m = 0;
            acc = 0;
            for (int j = 0; j < L; j++)
               if (hist.size() - 1 - j >= 0) acc += h[j] * longint'(hist[hist.size() - 1 - j]);
            v = (acc + (longint'(1) <<< (S - 1))) >>> S;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            expq.push_back('{edge_cnt + LAT, int'(v), real'(acc) / real'(longint'(1) <<< S)});
         end
      end
   end

   // Compare process: every cycle, strobe timing, value and hold behaviour.
   always @(negedge clk) begin
      bit   exp_v;
      exp_t e;
      real  d;
      if (edge_cnt > 0) begin
         exp_v = (expq.size() > 0) && (expq[0].due == edge_cnt);
         chk("dout_val", longint'(dout_val), longint'(exp_v));
         if (exp_v) begin
            e = expq.pop_front();
            last_dout = e.val;
            chk("dout", longint'(dout), longint'(e.val));
            d = real'(dout) - e.fval;
            if (d < 0.0) d = -d;
            chk("dout_vs_float", longint'(d <= 1.0), 1);
            $display("out edge=%0d dout=%0d expected=%0d", edge_cnt, dout, e.val);
         end else begin
            chk("dout_hold", longint'(dout), longint'(last_dout));
         end
         if (dout_val) begin
            obs_val.push_back(int'(dout));
            obs_cyc.push_back(edge_cnt);
         end
      end
   end

   task automatic send(input int v);
      din     = W_DIN'(v);
      din_val = 1'b1;
      @(negedge clk);
      din_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_obs(input string name, input int idx, input int req);
      if (idx < obs_val.size()) chk(name, longint'(obs_val[idx]), longint'(req));
      else chk({name, "_missing"}, longint'(obs_val.size()), longint'(idx + 1));
   endtask

   initial begin
      int s;
      int first_edge;
      int v;
      real t;
      rst_n   = 1'b0;
      din     = '0;
      din_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_dout", longint'(dout), 0);
      chk("reset_dout_val", longint'(dout_val), 0);
      rst_n = 1'b1;

      // Impulse of 64 on the first strobe: taps h[3], h[7] scaled by 64/64.
      s = obs_val.size();
      send(64);
      repeat (15) send(0);
      idle(8);
      chk_obs("impulse0", s, 10);
      chk_obs("impulse1", s + 1, 6);
      chk_obs("impulse2", s + 2, 0);
      chk_obs("impulse3", s + 3, 0);

      // DC 1000 from a clean start: exact from the third output on.
      do_reset();
      s = obs_val.size();
      repeat (24) send(1000);
      idle(8);
      for (int k = 2; k < 6; k++) chk_obs("dc1000", s + k, 1000);

      // Negative full scale, then positive full scale long enough to wrap.
      repeat (80) send(-32768);
      idle(8);
      chk_obs("dc_min", obs_val.size() - 1, -32768);
      repeat (400) send(32767);
      idle(8);
      chk_obs("dc_max_wrap", obs_val.size() - 1, 32767);

      // Back-to-back strobes: output every R clocks, LAT after capture.
      do_reset();
      s = obs_val.size();
      first_edge = edge_cnt + 1;
      repeat (16) send(0);
      idle(8);
      if (obs_cyc.size() >= s + 4) begin
         chk("latency_first", longint'(obs_cyc[s]), longint'(first_edge + R - 1 + LAT));
         for (int k = 1; k < 4; k++)
            chk("latency_spacing", longint'(obs_cyc[s + k] - obs_cyc[s + k - 1]), R);
      end else begin
         chk("latency_count", longint'(obs_cyc.size() - s), 4);
      end

      // Randomized samples with random gaps.
      for (int k = 0; k < 400; k++) begin
         send(int'($urandom_range(0, 65535)) - 32768);
         idle(int'($urandom_range(0, 3)));
      end
      idle(8);

      // Sparse two-tone input, one strobe every 30 clocks.
      s = obs_val.size();
      for (int k = 0; k < 40; k++) begin
         t = real'(k) * 30.0 * 10.0e-9;
         v = $rtoi(250.0 * $sin(6.283185307 * 10.0e3 * t) + 250.0 * $sin(6.283185307 * 200.0e3 * t));
         send(v * 64);
         idle(29);
      end
      idle(8);
      if (obs_cyc.size() >= s + 3) begin
         for (int k = s + 1; k < obs_cyc.size(); k++)
            chk("sparse_spacing", longint'(obs_cyc[k] - obs_cyc[k - 1]), 120);
      end else begin
         chk("sparse_count", longint'(obs_cyc.size() - s), 10);
      end

      // Reset while the phase counter sits at 2 with a token in flight.
      repeat (6) send(5000);
      do_reset();
      s = obs_val.size();
      first_edge = edge_cnt + 1;
      send(64);
      repeat (11) send(0);
      idle(8);
      if (obs_cyc.size() > s)
         chk("reset_mid_first_edge", longint'(obs_cyc[s]), longint'(first_edge + R - 1 + LAT));
      chk_obs("reset_mid_first_val", s, 10);
      chk_obs("reset_mid_second_val", s + 1, 6);

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_cic_dec.md
DSP_CIC_DEC -- requirements
Module: dsp_cic_dec

Interface
REQ-001 The block SHALL expose the following parameters:
- N, default 3: integrator/comb stage count, legal range 1..5.
- LOG2R, default 2: log2 of the decimation ratio R, legal range 1..5.
- W_DIN, default 16: input sample width, signed.
- W_DOUT, default 16: output sample width, signed; feeds the dsp_fir_dec din port.
REQ-002 The block SHALL derive the localparam W_ACC = W_DIN + N*LOG2R (accumulator width).
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- din  in  W_DIN: signed input sample.
- din_val  in  1: single-cycle strobe, din valid; any spacing of 1 clock or more.
- dout  out  W_DOUT: signed decimated sample.
- dout_val  out  1: single-cycle strobe, dout valid.

Function
REQ-004 Integrators: on each clock with din_val=1, the block SHALL update int[0] <= int[0] + sext(din) and int[k] <= int[k] + (new int[k-1]) for k=1..N-1, as a combinational chain with no inter-stage sample delay.
REQ-005 Integrator arithmetic SHALL be modular two's-complement at W_ACC bits, with wrap-around permitted and no saturation.
REQ-006 The phase counter SHALL count din_val strobes 0..R-1 and wrap to 0; it SHALL hold its value when din_val=0.
REQ-007 Decimation strobe: when din_val=1 and the phase counter is R-1, the block SHALL capture the new int[N-1] value into the comb input register at that same edge.
REQ-008 Combs: N pipelined stages SHALL advance one stage per clock, each stage computing c_k = x_k - x_k_prev, where x_k_prev is that stage's input on the previous decimated sample; the prev register SHALL update only when a valid token passes.
REQ-009 Comb arithmetic SHALL be modular at W_ACC bits.
REQ-010 Scaling: the output stage SHALL add 2^(N*LOG2R-1) to the comb result, arithmetic-shift it right by N*LOG2R, and saturate to [-2^(W_DOUT-1), 2^(W_DOUT-1)-1].
REQ-011 Latency: dout_val SHALL be 1 for exactly one cycle, registered, N+1 clocks after the edge that captures the decimation strobe.
REQ-012 dout SHALL hold its last value between strobes.
REQ-013 Throughput: the block SHALL produce one output per R input strobes, with no stall and no back-pressure; back-to-back din_val every clock SHALL be supported.
REQ-014 With DC input x held for at least N decimated samples, dout SHALL equal x exactly, because the gain R^N is cancelled exactly by the shift.
REQ-015 Downstream contract: the dsp_fir_dec CLOCK_PER_SAMPLE parameter SHALL be at least R times the upstream din_val spacing.

Reset
REQ-016 While rst_n=0, the block SHALL asynchronously clear all integrators, comb registers, prev registers, the phase counter, the valid pipeline, dout and dout_val to 0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight tokens; no dout_val SHALL appear until R new din_val strobes plus the latency have elapsed.
REQ-018 After reset the phase counter SHALL be 0, so the first decimation strobe is the R-th din_val.

Structure
REQ-019 A shared header SHALL hold the W_ACC and shift-amount derivation and the saturation bounds; it SHALL be reused by dsp_fir_dec benches.
REQ-020 The comb stage SHALL be one sub-module, dsp_cic_comb_stage (parameter W; ports: value, valid, prev register), instantiated N times via generate.
REQ-021 Integrators, phase counter and output stage SHALL live in the top module.

Verification (N=3, LOG2R=2, W_DIN=W_DOUT=16)
REQ-022 Impulse: din=64 on the first din_val after reset, then zeros -> dout sequence 10, 6, 0, 0, matching taps h[3] and h[7] of 1,3,6,10,12,12,10,6,3,1.
REQ-023 DC: din=1000 constant -> dout=1000 from the third output onward; din=-32768 -> -32768; din=32767 -> 32767; no spurious saturation.
REQ-024 Latency: din_val every clock -> dout_val pulses exactly every 4 clocks, each 4 clocks after its capturing edge (N+1=4).
REQ-025 Sparse input: din_val every 30 clocks with a 10 kHz+200 kHz sine (samples <<6) -> dout_val every 120 clocks; the 200 kHz component is attenuated relative to a floating-point CIC model within ±1 LSB.
REQ-026 Wrap: a full-scale DC input run for more than 2^W_ACC/32767 samples -> the integrators wrap, and dout still equals the DC value.
REQ-027 Reset mid-stream: pulse rst_n low during phase 2 -> no dout_val until 4 new strobes + 4 clocks; the first output matches a fresh-start model.
